// File: rtl/random_recall_if.sv
// rtl/random_recall_if.sv - control pulses and display outputs of random_recall
interface random_recall_if #(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
);
    logic          i_start;
    logic          i_done;
    logic [3:0]    i_value;
    logic          i_recall;
    logic [6:0]    o_seven_ten;
    logic [6:0]    o_seven_one;
    logic [IW-1:0] o_hist_idx;
    logic          o_busy;

    modport master (
        output i_start, i_done, i_value, i_recall,
        input  o_seven_ten, o_seven_one, o_hist_idx, o_busy
    );

    modport slave (
        input  i_start, i_done, i_value, i_recall,
        output o_seven_ten, o_seven_one, o_hist_idx, o_busy
    );
endinterface

// File: rtl/random_recall.sv
// rtl/random_recall.sv - live/recall seven-segment display of generator results
module random_recall #(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    random_recall_if.slave  bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [IW:0] FULL  = DEPTH[IW:0];
    localparam logic [6:0]  BLANK = 7'b1111111;

    state_t        state, state_nx;
    logic [3:0]    hist [DEPTH];
    logic [IW-1:0] wptr;
    logic [IW-1:0] ptr;
    logic [IW:0]   cnt;

    logic [IW-1:0] sel;
    logic [3:0]    show_v;
    logic          show_blank;

    logic [6:0]    ten_q, one_q;
    logic [IW-1:0] idx_q;
    logic          busy_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = BLANK;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.i_start) state_nx = S_RUN;
            S_RUN:   if (bus.i_done)  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // History ring: wptr points at the next slot, ptr is the age being recalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= 4'd0;
            wptr <= '0;
            ptr  <= '0;
            cnt  <= '0;
        end else if (state == S_IDLE) begin
            if (bus.i_start)
                ptr <= '0;
            else if (bus.i_recall && cnt != '0)
                ptr <= (({1'b0, ptr} + 1'b1) == cnt) ? '0 : ptr + 1'b1;
        end else if (bus.i_done) begin
            hist[wptr] <= bus.i_value;
            wptr       <= wptr + 1'b1;
            ptr        <= '0;
            if (cnt != FULL) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        sel        = wptr - 1'b1 - ptr;
        show_blank = 1'b0;
        if (state == S_RUN) begin
            show_v = bus.i_value;
        end else begin
            show_v     = hist[sel];
            show_blank = (cnt == '0);
        end
    end

    // Output stage sees the pre-edge state, so the done edge still shows i_value
    // and the idle view of the same captured value follows one edge later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ten_q  <= BLANK;
            one_q  <= BLANK;
            idx_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state == S_RUN);
            idx_q  <= (state == S_RUN) ? '0 : ptr;
            if (show_blank) begin
                ten_q <= BLANK;
                one_q <= BLANK;
            end else if (show_v >= 4'd10) begin
                ten_q <= seg7(4'd1);
                one_q <= seg7(show_v - 4'd10);
            end else begin
                ten_q <= seg7(4'd0);
                one_q <= seg7(show_v);
            end
        end
    end

    assign bus.o_seven_ten = ten_q;
    assign bus.o_seven_one = one_q;
    assign bus.o_hist_idx  = idx_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_random_recall.sv
// tb/tb_random_recall.sv - directed self-checking bench for random_recall
module tb_random_recall;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    random_recall_if #(.DEPTH(4)) bus();

    random_recall #(.DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // v < 0 means blank
    function automatic logic [13:0] disp(input int v);
        if (v < 0) return {7'b1111111, 7'b1111111};
        if (v >= 10) return {seg_tab[1], seg_tab[v - 10]};
        return {seg_tab[0], seg_tab[v]};
    endfunction

    task automatic check_out(input string tag, input int v, input int idx, input logic busy);
        check({tag, "_disp"}, {18'd0, bus.o_seven_ten, bus.o_seven_one}, {18'd0, disp(v)});
        check({tag, "_idx"},  {30'd0, bus.o_hist_idx}, idx);
        check({tag, "_busy"}, {31'd0, bus.o_busy}, {31'd0, busy});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_once(input logic [3:0] v);
        bus.i_start = 1'b1; bus.i_value = v; tick();
        bus.i_start = 1'b0; tick();
        bus.i_done  = 1'b1; tick();
        bus.i_done  = 1'b0; tick();
    endtask

    task automatic recall_once();
        bus.i_recall = 1'b1; tick();
        bus.i_recall = 1'b0; tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(); tick();
        rst_n = 1'b1; tick();
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_done = 1'b0; bus.i_recall = 1'b0; bus.i_value = 4'd0;

        // reset state and recall on empty history
        tick();
        check_out("rst", -1, 0, 1'b0);
        rst_n = 1'b1; tick();
        recall_once();
        check_out("rst_recall", -1, 0, 1'b0);

        // live follow 3,12,7 then capture 7
        bus.i_start = 1'b1; bus.i_value = 4'd3; tick();
        bus.i_start = 1'b0; bus.i_value = 4'd12;
        check_out("run_e0", -1, 0, 1'b0);
        tick();
        check_out("run_12", 12, 0, 1'b1);
        bus.i_value = 4'd7; tick();
        check_out("run_7", 7, 0, 1'b1);
        bus.i_done = 1'b1; tick();
        bus.i_done = 1'b0; bus.i_value = 4'd2;
        check_out("done_edge", 7, 0, 1'b1);
        tick();
        check_out("idle_7", 7, 0, 1'b0);

        // three runs, recall wraps at count 3
        do_reset();
        run_once(4'd1); run_once(4'd15); run_once(4'd9);
        check_out("h3_latest", 9, 0, 1'b0);
        recall_once(); check_out("h3_r1", 15, 1, 1'b0);
        recall_once(); check_out("h3_r2", 1, 2, 1'b0);
        recall_once(); check_out("h3_wrap", 9, 0, 1'b0);

        // five runs overwrite oldest; back-to-back recalls
        do_reset();
        for (int i = 1; i <= 5; i++) run_once(4'(i));
        check_out("h5_latest", 5, 0, 1'b0);
        bus.i_recall = 1'b1; tick();
        tick(); check_out("h5_r1", 4, 1, 1'b0);
        tick(); check_out("h5_r2", 3, 2, 1'b0);
        tick(); check_out("h5_r3", 2, 3, 1'b0);
        bus.i_recall = 1'b0; tick();
        check_out("h5_wrap", 5, 0, 1'b0);

        // start beats recall; pulses ignored during the run
        recall_once(); check_out("pre_start", 4, 1, 1'b0);
        bus.i_start = 1'b1; bus.i_recall = 1'b1; bus.i_value = 4'd8; tick();
        bus.i_start = 1'b0; bus.i_recall = 1'b0; tick();
        check_out("sr_run", 8, 0, 1'b1);
        bus.i_recall = 1'b1; bus.i_start = 1'b1; bus.i_value = 4'd11; tick();
        bus.i_recall = 1'b0; bus.i_start = 1'b0; tick();
        check_out("run_ign", 11, 0, 1'b1);
        bus.i_done = 1'b1; bus.i_value = 4'd6; tick();
        bus.i_done = 1'b0; tick();
        check_out("sr_idle", 6, 0, 1'b0);
        recall_once(); check_out("sr_hist", 5, 1, 1'b0);

        // reset mid-run after two captures
        do_reset();
        run_once(4'd2); run_once(4'd3);
        bus.i_start = 1'b1; bus.i_value = 4'd8; tick();
        bus.i_start = 1'b0; tick();
        check_out("mid_run", 8, 0, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", -1, 0, 1'b0);
        tick(); rst_n = 1'b1; tick();
        bus.i_done = 1'b1; bus.i_value = 4'd4; tick();
        bus.i_done = 1'b0; tick();
        check_out("idle_done", -1, 0, 1'b0);
        recall_once();
        check_out("post_rst_recall", -1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
